// File: rtl/m_controller.sv
// m_controller: sequencing FSM for the RV32M multiply/divide datapath.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start, funct3          operation request (sampled in IDLE) and RV32M op code
//   rs1_sign, rs2_sign     bit 31 of the operands
//   rs2_zero               divisor is zero
//   flush                  abort the operation in flight
//   sub_neg                subtractor borrow from m_registers
//   mux_multA, mux_multB   multiplier operand selects (ZERO/SIGNED/UNSIGNED)
//   mux_R, mux_D, mux_Z    remainder / divisor / quotient register selects
//   busy, done             operation in flight / one-cycle completion pulse
//   res_sel, res_negate    result source (0 = R, 1 = Z) and writeback negate
module m_controller #(
  parameter int MULT_LATENCY = 1,
  localparam int MUX_MULTA_LENGTH = 2,
  localparam int MUX_MULTB_LENGTH = 2,
  localparam int MUX_R_LENGTH = 3,
  localparam int MUX_D_LENGTH = 2,
  localparam int MUX_Z_LENGTH = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [2:0]                  funct3,
  input  logic                        rs1_sign,
  input  logic                        rs2_sign,
  input  logic                        rs2_zero,
  input  logic                        flush,
  input  logic                        sub_neg,
  output logic [MUX_MULTA_LENGTH-1:0] mux_multA,
  output logic [MUX_MULTB_LENGTH-1:0] mux_multB,
  output logic [MUX_R_LENGTH-1:0]     mux_R,
  output logic [MUX_D_LENGTH-1:0]     mux_D,
  output logic [MUX_Z_LENGTH-1:0]     mux_Z,
  output logic                        busy,
  output logic                        done,
  output logic                        res_sel,
  output logic                        res_negate
);
  localparam logic [1:0] MA_ZERO = 2'd0, MA_SIGNED = 2'd1, MA_UNSIGNED = 2'd2;
  localparam logic [1:0] MB_ZERO = 2'd0, MB_SIGNED = 2'd1, MB_UNSIGNED = 2'd2;
  localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_A_NEG = 3'd2, R_SUB_KEEP = 3'd3, R_MULT_LOWER = 3'd4;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL_ADD = 2'd2, Z_MULT_UPPER = 2'd3;
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULHU = 3'd3, OP_DIV = 3'd4, OP_REM = 3'd6;
  localparam logic [4:0] WAIT_LAST = 5'(MULT_LATENCY);

  typedef enum logic [2:0] {IDLE, MUL_OP, MUL_WAIT, MUL_WB, DIV_ITER, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        accept;
  logic        sdiv;
  logic        in_mul;
  logic        unused_sub_neg;

  // The restore-or-keep decision is made inside m_registers under SUB_KEEP.
  assign unused_sub_neg = sub_neg;
  // A flush or reset in IDLE swallows a simultaneous start.
  assign accept = resetn && state_q == IDLE && start && !flush;
  assign sdiv   = funct3[2] && !funct3[0];
  assign in_mul = state_q == MUL_OP || state_q == MUL_WAIT || state_q == MUL_WB;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = funct3;
        negq_d  = funct3 == OP_DIV && (rs1_sign ^ rs2_sign) && !rs2_zero;
        negr_d  = funct3 == OP_REM && rs1_sign;
        state_d = funct3[2] ? DIV_ITER : MUL_OP;
      end
      MUL_OP: state_d = MUL_WAIT;
      MUL_WAIT: begin
        cnt_d   = cnt_q == WAIT_LAST ? 5'd0 : cnt_q + 5'd1;
        state_d = cnt_q == WAIT_LAST ? MUL_WB : MUL_WAIT;
      end
      MUL_WB: state_d = DONE;
      DIV_ITER: begin
        cnt_d   = cnt_q + 5'd1;
        state_d = &cnt_q ? DONE : DIV_ITER;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= OP_MUL;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  always_comb begin
    mux_R     = R_KEEP;
    mux_D     = D_KEEP;
    mux_Z     = Z_KEEP;
    mux_multA = MA_ZERO;
    mux_multB = MB_ZERO;
    if (accept) begin
      mux_R = sdiv && rs1_sign ? R_A_NEG : R_A;
      mux_D = sdiv && rs2_sign ? D_B_NEG : D_B;
      mux_Z = funct3[2] ? Z_ZERO : Z_KEEP;
    end
    // Held through MUL_WB: m_registers picks the signed upper half from these.
    if (in_mul) begin
      mux_multA = op_q == OP_MULHU ? MA_UNSIGNED : MA_SIGNED;
      mux_multB = op_q[1] ? MB_UNSIGNED : MB_SIGNED;
    end
    if (state_q == MUL_WB) begin
      mux_R = op_q == OP_MUL ? R_MULT_LOWER : R_KEEP;
      mux_Z = op_q == OP_MUL ? Z_KEEP : Z_MULT_UPPER;
    end
    if (state_q == DIV_ITER) begin
      mux_R = R_SUB_KEEP;
      mux_D = D_SHR;
      mux_Z = Z_SHL_ADD;
    end
  end

  assign busy       = in_mul || state_q == DIV_ITER;
  assign done       = state_q == DONE;
  assign res_sel    = op_q[2] ? !op_q[1] : |op_q[1:0];
  assign res_negate = op_q == OP_DIV ? negq_q : op_q == OP_REM && negr_q;
endmodule

// File: tb/tb_m_controller.sv
// tb_m_controller: self-checking bench for m_controller with a behavioural m_registers stand-in.
module tb_m_controller;
  localparam logic [1:0] MA_ZERO = 2'd0, MA_S = 2'd1, MA_U = 2'd2;
  localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_ANEG = 3'd2, R_SUB = 3'd3, R_LOW = 3'd4;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_BNEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL = 2'd2, Z_UP = 2'd3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        rs1_sign, rs2_sign, rs2_zero, sub_neg;
  logic [1:0]  mux_multA, mux_multB, mux_D, mux_Z;
  logic [2:0]  mux_R;
  logic        busy, done, res_sel, res_negate;
  logic [63:0] R, D, ma, mb, prod, P;
  logic [31:0] Z;
  int          errors = 0;
  int          checks = 0;

  m_controller dut (
    .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero),
    .flush(flush), .sub_neg(sub_neg),
    .mux_multA(mux_multA), .mux_multB(mux_multB), .mux_R(mux_R),
    .mux_D(mux_D), .mux_Z(mux_Z), .busy(busy), .done(done),
    .res_sel(res_sel), .res_negate(res_negate)
  );

  always #5 clk = ~clk;

  assign rs1_sign = rs1[31];
  assign rs2_sign = rs2[31];
  assign rs2_zero = rs2 == 32'd0;
  assign sub_neg  = R < D;

  // Datapath stand-in: restoring divider on magnitudes plus a one-stage multiplier.
  always @(posedge clk) begin
    case (mux_R)
      R_A:     R <= {32'b0, rs1};
      R_ANEG:  R <= {32'b0, -rs1};
      R_SUB:   if (!sub_neg) R <= R - D;
      R_LOW:   R <= {32'b0, P[31:0]};
      default: ;
    endcase
    case (mux_D)
      D_B:     D <= {32'b0, rs2} << 31;
      D_BNEG:  D <= {32'b0, -rs2} << 31;
      D_SHR:   D <= D >> 1;
      default: ;
    endcase
    case (mux_Z)
      Z_ZERO:  Z <= 32'd0;
      Z_SHL:   Z <= {Z[30:0], !sub_neg};
      Z_UP:    Z <= P[63:32];
      default: ;
    endcase
    ma   <= mux_multA == MA_S ? {{32{rs1[31]}}, rs1} : mux_multA == MA_U ? {32'b0, rs1} : 64'd0;
    mb   <= mux_multB == MA_S ? {{32{rs2[31]}}, rs2} : mux_multB == MA_U ? {32'b0, rs2} : 64'd0;
    prod <= ma * mb;
    P    <= prod;
  end

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic ovf;
    ea  = f == 3'd3 ? {32'b0, a} : {{32{a[31]}}, a};
    eb  = f <= 3'd1 ? {{32{b[31]}}, b} : {32'b0, b};
    p   = ea * eb;
    ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    int iters;
    bit seen;
    logic sd;
    logic exp_sel, exp_neg;
    logic [31:0] res, want;
    sd = f[2] && !f[0];
    exp_sel = f >= 3'd1 && f <= 3'd5;
    exp_neg = f == 3'd4 ? (a[31] ^ b[31]) && b != 0 : f == 3'd6 ? a[31] : 1'b0;
    want = ref_res(f, a, b);
    rs1 = a; rs2 = b; funct3 = f; start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy f=%0d: got %b want 0", f, busy); end
    checks++;
    if ({mux_R, mux_D, mux_Z} !== {sd && a[31] ? R_ANEG : R_A, sd && b[31] ? D_BNEG : D_B, f[2] ? Z_ZERO : Z_KEEP}) begin
      errors++; $display("FAIL accept_sel f=%0d: got R=%0d D=%0d Z=%0d", f, mux_R, mux_D, mux_Z);
    end
    @(negedge clk);
    start = 1'b0;
    n = 1; iters = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL inflight_busy f=%0d n=%0d: got %b want 1", f, n, busy); end
        if (!f[2]) begin
          checks++;
          if ({mux_multA, mux_multB} !== {f == 3'd3 ? MA_U : MA_S, f[1] ? MA_U : MA_S}) begin
            errors++; $display("FAIL mult_sel f=%0d n=%0d: got A=%0d B=%0d", f, n, mux_multA, mux_multB);
          end
        end
        if (mux_R === R_SUB) iters++;
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout f=%0d: no done within %0d cycles", f, n); end
    else begin
      checks++;
      if (n != (f[2] ? 33 : 5)) begin errors++; $display("FAIL latency f=%0d: got %0d want %0d", f, n, f[2] ? 33 : 5); end
      if (f[2]) begin
        checks++;
        if (iters != 32) begin errors++; $display("FAIL div_iters f=%0d: got %0d want 32", f, iters); end
      end
      checks++;
      if ({busy, mux_multA, mux_multB} !== {1'b0, MA_ZERO, MA_ZERO}) begin
        errors++; $display("FAIL done_outputs f=%0d: got busy=%b A=%0d B=%0d", f, busy, mux_multA, mux_multB);
      end
      checks++;
      if (res_sel !== exp_sel) begin errors++; $display("FAIL res_sel f=%0d: got %b want %b", f, res_sel, exp_sel); end
      checks++;
      if (res_negate !== exp_neg) begin errors++; $display("FAIL res_negate f=%0d a=%h b=%h: got %b want %b", f, a, b, res_negate, exp_neg); end
      res = res_sel ? Z : R[31:0];
      if (res_negate) res = -res;
      checks++;
      if (res !== want) begin errors++; $display("FAIL result f=%0d a=%h b=%h: got %h want %h", f, a, b, res, want); end
    end
  endtask

  task automatic test_reset();
    start = 1'b1; funct3 = 3'd4; rs1 = 32'hFFFFFFF0; rs2 = 32'h80000001;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, res_sel, res_negate, mux_R, mux_D, mux_Z, mux_multA, mux_multB} !==
        {4'b0, R_KEEP, D_KEEP, Z_KEEP, MA_ZERO, MA_ZERO}) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b sel=%b neg=%b R=%0d D=%0d Z=%0d", busy, done, res_sel, res_negate, mux_R, mux_D, mux_Z);
    end
    start = 1'b0; resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD);            @(negedge clk);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);     @(negedge clk);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);     @(negedge clk);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);     @(negedge clk);
    run_op(3'd4, 32'hFFFFFFEC, 32'd3);            @(negedge clk);
    run_op(3'd6, 32'hFFFFFFEC, 32'd3);            @(negedge clk);
    run_op(3'd5, 32'h1234, 32'd0);                @(negedge clk);
    run_op(3'd4, 32'hFFFFFFFB, 32'd0);            @(negedge clk);
    run_op(3'd6, 32'hFFFFFFFB, 32'd0);            @(negedge clk);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF);     @(negedge clk);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF);     @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bad;
    run_op(3'd7, 32'd100, 32'd9);
    start = 1'b1; funct3 = 3'd0;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (8) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL start_in_done: got %0d active cycles want 0", bad); end
    run_op(3'd5, 32'hDEADBEEF, 32'd16);
    @(negedge clk);
    run_op(3'd0, 32'h00010001, 32'h00010001);
    @(negedge clk);
  endtask

  task automatic test_flush();
    int bad;
    rs1 = 32'd1000; rs2 = 32'd7; funct3 = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (mux_R !== R_SUB || busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got R=%0d busy=%b want 3 1", mux_R, busy); end
    flush = 1'b1; start = 1'b1; funct3 = 3'd3;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b done=%b want 0 0", busy, done); end
    bad = 0;
    repeat (40) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flush_no_done: got %0d active cycles want 0", bad); end
    flush = 1'b1; start = 1'b1; funct3 = 3'd4;
    #1;
    checks++;
    if (mux_R !== R_KEEP || mux_Z !== Z_KEEP) begin errors++; $display("FAIL idle_flush_sel: got R=%0d Z=%0d want 0 0", mux_R, mux_Z); end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_start: got busy=%b want 0", busy); end
    run_op(3'd3, 32'hFFFFFFFF, 32'd2);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; funct3 = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || res_sel !== 1'b1 || mux_multA !== MA_S) begin
      errors++; $display("FAIL mid_mult: got busy=%b sel=%b A=%0d want 1 1 1", busy, res_sel, mux_multA);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, res_sel, res_negate, mux_R, mux_D, mux_Z, mux_multA, mux_multB} !==
        {4'b0, R_KEEP, D_KEEP, Z_KEEP, MA_ZERO, MA_ZERO}) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b sel=%b neg=%b A=%0d B=%0d", busy, done, res_sel, res_negate, mux_multA, mux_multB);
    end
    resetn = 1'b1;
    @(negedge clk);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 7));
        default: b = $urandom;
      endcase
      run_op(f, a, b);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
